// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: packs decoded posit product fields into a posit word.
// The inputs are sign, summed regime, exponent sum and the raw mantissa product.
// The result is normalised, rounded to nearest even and saturated.
// The datapath is a three-stage collapsing valid/ready pipeline.
module posit_encode_pipe #(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int REGI  = $clog2(WIDTH) + 1,
  parameter int MTS   = WIDTH - 3 - EXP
) (
  input  logic                 clk_i,
  input  logic                 rstn,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 sign_m,
  input  logic [REGI:0]        regi_m,
  input  logic [EXP:0]         exp_m,
  input  logic [2*(MTS+1)-1:0] mts_m,
  input  logic                 is_zero,
  input  logic                 is_nar,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     posit_o
);
  localparam int SW = REGI + EXP + 2;         // scale width
  localparam int KW = SW - EXP;               // regime value width
  localparam int MW = 2 * (MTS + 1);          // mantissa product width
  localparam int FW = 2 * MTS + 1;            // aligned fraction width
  localparam int BW = WIDTH - 1;              // body width (word minus sign)
  localparam int LW = 2 + EXP + FW + WIDTH;   // regime marker, e, F, plus shift room
  localparam logic signed [KW-1:0] K_MAX = KW'(WIDTH - 2);
  localparam logic signed [KW-1:0] K_MIN = KW'(-(WIDTH - 2));

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  logic          s1_sign, s1_zero, s1_nar;
  logic [SW-1:0] s1_scale;
  logic [FW-1:0] s1_frac;

  logic          s2_sign, s2_zero, s2_nar;
  logic [BW-1:0] s2_body;
  logic          s2_guard, s2_sticky, s2_sat_hi, s2_sat_lo;

  logic [WIDTH-1:0] posit_q;

  // A stage loads when it is empty or its contents advance; this makes bubbles collapse.
  always_comb begin
    ld3 = !v3 || out_rdy;
    ld2 = !v2 || ld3;
    ld1 = !v1 || ld2;
  end

  assign in_rdy  = ld1;
  assign out_vld = v3;
  assign posit_o = posit_q;

  // Stage 1 datapath: a mantissa overflow (10.xxx) bumps the scale, and the leading one is stripped.
  logic          n_c;
  logic [SW-1:0] scale_c;
  logic [FW-1:0] frac_c;
  always_comb begin
    n_c     = mts_m[MW-1];
    scale_c = {regi_m[REGI], regi_m, {EXP{1'b0}}}
            + {{(SW-EXP-1){1'b0}}, exp_m}
            + {{(SW-1){1'b0}}, n_c};
    frac_c  = n_c ? mts_m[FW-1:0] : {mts_m[FW-2:0], 1'b0};
  end

  // Stage 1 register: captures the normalised scale, the fraction and the special flags.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      v1       <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_scale <= '0;
      s1_frac  <= '0;
    end else if (ld1) begin
      v1       <= in_vld;
      s1_sign  <= sign_m;
      s1_zero  <= is_zero;
      s1_nar   <= is_nar;
      s1_scale <= scale_c;
      s1_frac  <= frac_c;
    end
  end

  // Stage 2 datapath: the regime run is built by arithmetically shifting a "10" or "01" marker.
  // Everything shifted past the body feeds the guard and sticky bits.
  logic signed [KW-1:0] k_c;
  logic [EXP-1:0]       e_c;
  logic [KW-1:0]        sh_c;
  logic signed [LW-1:0] base_c, run_c;
  logic [BW-1:0]        body_c;
  logic                 guard_c, sticky_c, sat_hi_c, sat_lo_c;
  always_comb begin
    k_c      = s1_scale[SW-1:EXP];
    e_c      = s1_scale[EXP-1:0];
    sh_c     = k_c ^ {KW{k_c[KW-1]}};
    base_c   = {(k_c[KW-1] ? 2'b01 : 2'b10), e_c, s1_frac, {WIDTH{1'b0}}};
    run_c    = base_c >>> sh_c;
    body_c   = run_c[LW-1 -: BW];
    guard_c  = run_c[LW-1-BW];
    sticky_c = |run_c[LW-2-BW:0];
    sat_hi_c = k_c > K_MAX;
    sat_lo_c = k_c < K_MIN;
  end

  // Stage 2 register: holds the truncated body, the rounding bits and the saturation flags.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      v2        <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_nar    <= 1'b0;
      s2_body   <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_sat_hi <= 1'b0;
      s2_sat_lo <= 1'b0;
    end else if (ld2) begin
      v2        <= v1;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_nar    <= s1_nar;
      s2_body   <= body_c;
      s2_guard  <= guard_c;
      s2_sticky <= sticky_c;
      s2_sat_hi <= sat_hi_c;
      s2_sat_lo <= sat_lo_c;
    end
  end

  // Stage 3 datapath: round to nearest even, never carrying out of maxpos, then saturate.
  // Negate negative results and let NaR, then zero, override the word.
  logic             round_c;
  logic [BW-1:0]    body_r;
  logic [WIDTH-1:0] mag_c, word_c;
  always_comb begin
    round_c = s2_guard && (s2_sticky || s2_body[0]) && !(&s2_body);
    if (s2_sat_hi)      body_r = '1;
    else if (s2_sat_lo) body_r = {{(BW-1){1'b0}}, 1'b1};
    else                body_r = s2_body + {{(BW-1){1'b0}}, round_c};
    mag_c  = {1'b0, body_r};
    word_c = s2_sign ? -mag_c : mag_c;
    if (s2_nar)       word_c = {1'b1, {BW{1'b0}}};
    else if (s2_zero) word_c = '0;
  end

  // Stage 3 register: the output word, held while downstream stalls.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      v3      <= 1'b0;
      posit_q <= '0;
    end else if (ld3) begin
      v3      <= v2;
      posit_q <= word_c;
    end
  end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// tb_posit_encode_pipe: directed and randomised bench for posit_encode_pipe (WIDTH=8, EXP=2).
module tb_posit_encode_pipe;
  logic       clk_i = 1'b0;
  logic       rstn;
  logic       in_vld;
  logic       in_rdy;
  logic       sign_m;
  logic [4:0] regi_m;
  logic [2:0] exp_m;
  logic [7:0] mts_m;
  logic       is_zero;
  logic       is_nar;
  logic       out_vld;
  logic       out_rdy;
  logic [7:0] posit_o;

  logic [7:0] sb[$];
  int         checks = 0;
  int         errors = 0;
  int         out_count = 0;
  bit         rand_rdy = 1'b0;

  posit_encode_pipe #(.WIDTH(8), .EXP(2)) dut (
    .clk_i(clk_i), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy),
    .sign_m(sign_m), .regi_m(regi_m), .exp_m(exp_m), .mts_m(mts_m),
    .is_zero(is_zero), .is_nar(is_nar), .out_vld(out_vld), .out_rdy(out_rdy),
    .posit_o(posit_o)
  );

  // Free-running clock, period 10.
  initial forever #5 clk_i = ~clk_i;

  // Bit-serial reference encoder: it writes out the regime, e and F, then reads off the body, guard and sticky bits.
  function automatic logic [7:0] refEncode(input logic s, input logic signed [4:0] r,
                                           input logic [2:0] ex, input logic [7:0] m,
                                           input logic z, input logic nr);
    int         sc, k, e;
    logic [6:0] fr, body;
    logic [7:0] mag;
    bit         q[$];
    bit         g, st;
    if (nr) return 8'h80;
    if (z)  return 8'h00;
    sc = int'(r) * 4 + int'(ex) + int'(m[7]);
    k  = sc >>> 2;
    e  = sc - 4 * k;
    fr = m[7] ? m[6:0] : {m[5:0], 1'b0};
    if (k > 6)       mag = 8'h7F;
    else if (k < -6) mag = 8'h01;
    else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 6; i >= 0; i--) q.push_back(fr[i]);
      body = '0;
      for (int i = 0; i < 7; i++) body = {body[5:0], q[i]};
      g  = q[7];
      st = 1'b0;
      for (int i = 8; i < q.size(); i++) st = st | q[i];
      if (g && (st || body[0]) && body != 7'h7F) body = body + 7'd1;
      mag = {1'b0, body};
    end
    return s ? (8'd0 - mag) : mag;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] r, input logic [2:0] ex,
                               input logic [7:0] m, input logic z, input logic nr,
                               input logic [7:0] expv, input string tag);
    bit done = 1'b0;
    sign_m = s; regi_m = r; exp_m = ex; mts_m = m; is_zero = z; is_nar = nr;
    in_vld = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      if (in_rdy === 1'b1) begin
        sb.push_back(expv);
        done = 1'b1;
      end
    end
    @(posedge clk_i); #1;
    checkOutput({tag, " accept"}, 32'(done), 32'd1);
  endtask

  task automatic checkLatency(input string tag);
    int lat = 1;
    in_vld = 1'b0;
    while (out_vld !== 1'b1 && lat < 10) begin
      @(posedge clk_i); #1;
      lat++;
    end
    checkOutput(tag, 32'(lat), 32'd3);
  endtask

  task automatic waitDrain(input string tag);
    in_vld = 1'b0;
    for (int c = 0; c < 500 && sb.size() > 0; c++) @(posedge clk_i);
    @(posedge clk_i); #1;
    checkOutput(tag, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: a transfer seen at the negedge completes on the next posedge.
  initial begin
    logic [7:0] expv;
    forever begin
      @(negedge clk_i);
      if (rstn === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
        if (sb.size() == 0) checkOutput("spurious output", 32'(out_vld), 32'd0);
        else begin
          expv = sb.pop_front();
          checkOutput($sformatf("out%0d", out_count), 32'(posit_o), 32'(expv));
        end
        out_count++;
      end
    end
  end

  // Random out_rdy toggling, active only while rand_rdy is set.
  initial forever begin
    @(posedge clk_i); #1;
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
  end

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence: reset, test-plan vectors, backpressure, random stalls, reset mid-flight.
  initial begin
    int outs_before;
    int stale;
    logic       rs, rz, rn;
    logic [4:0] rr;
    logic [2:0] rx;
    logic [7:0] rm, re;

    rstn = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    sign_m = 1'b0; regi_m = '0; exp_m = '0; mts_m = '0; is_zero = 1'b0; is_nar = 1'b0;
    #1;
    checkOutput("reset out_vld", 32'(out_vld), 32'd0);
    checkOutput("reset posit_o", 32'(posit_o), 32'd0);
    #11 rstn = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("reset in_rdy", 32'(in_rdy), 32'd1);

    $display("[TB] directed vectors");
    applyStimulus(0, 5'd0, 3'd0, 8'h40, 0, 0, 8'h40, "1.0x1.0");
    checkLatency("latency 1.0x1.0");
    applyStimulus(0, 5'd0, 3'd2, 8'h40, 0, 0, 8'h50, "2.0x2.0");
    applyStimulus(0, 5'd0, 3'd0, 8'h90, 0, 0, 8'h49, "1.5x1.5");
    applyStimulus(1, 5'd0, 3'd0, 8'h40, 0, 0, 8'hC0, "-1.0");
    applyStimulus(0, 5'd0, 3'd0, 8'h44, 0, 0, 8'h40, "tie even");
    applyStimulus(0, 5'd0, 3'd0, 8'h4C, 0, 0, 8'h42, "tie odd");
    applyStimulus(0, 5'd0, 3'd0, 8'h45, 0, 0, 8'h41, "guard sticky");
    applyStimulus(0, 5'd7, 3'd0, 8'h40, 0, 0, 8'h7F, "sat hi");
    applyStimulus(1, 5'd7, 3'd0, 8'h40, 0, 0, 8'h81, "sat hi neg");
    applyStimulus(0, 5'h18, 3'd0, 8'h40, 0, 0, 8'h01, "sat lo");
    applyStimulus(0, 5'd0, 3'd0, 8'h40, 1, 0, 8'h00, "zero");
    applyStimulus(0, 5'd0, 3'd0, 8'h40, 0, 1, 8'h80, "nar");
    applyStimulus(1, 5'd3, 3'd1, 8'h90, 1, 1, 8'h80, "zero+nar");
    waitDrain("directed drain");

    $display("[TB] backpressure");
    outs_before = out_count;
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rr = 5'(i - 1); rx = 3'(i); rm = 8'(8'h40 + 8'h13 * i);
      applyStimulus(i[0], rr, rx, rm, 0, 0, refEncode(i[0], rr, rx, rm, 0, 0), "bp fill");
    end
    regi_m = 5'd2; exp_m = 3'd3; mts_m = 8'hA9; sign_m = 1'b1; in_vld = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("bp accepted", 32'(sb.size()), 32'd3);
    checkOutput("bp in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("bp hold vld", 32'(out_vld), 32'd1);
    checkOutput("bp hold data", 32'(posit_o), 32'(sb[0]));
    repeat (2) @(negedge clk_i);
    checkOutput("bp stable data", 32'(posit_o), 32'(sb[0]));
    @(posedge clk_i); #1;
    out_rdy = 1'b1;
    applyStimulus(1, 5'd2, 3'd3, 8'hA9, 0, 0, refEncode(1, 5'd2, 3'd3, 8'hA9, 0, 0), "bp item3");
    applyStimulus(0, 5'h1D, 3'd5, 8'h71, 0, 0, refEncode(0, 5'h1D, 3'd5, 8'h71, 0, 0), "bp item4");
    waitDrain("bp drain");
    checkOutput("bp result count", 32'(out_count - outs_before), 32'd5);

    $display("[TB] random stalls");
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7) - 4);
      rx = 3'($urandom_range(0, 6));
      rm = 8'($urandom_range(8, 15) * $urandom_range(8, 15));
      rz = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 15) == 0);
      re = refEncode(rs, rr, rx, rm, rz, rn);
      applyStimulus(rs, rr, rx, rm, rz, rn, re, "rand");
      if ($urandom_range(0, 3) == 0) begin
        in_vld = 1'b0;
        @(posedge clk_i); #1;
      end
    end
    in_vld = 1'b0;
    @(negedge clk_i); #2;
    rand_rdy = 1'b0;
    out_rdy = 1'b1;
    waitDrain("random drain");

    $display("[TB] reset mid-flight");
    applyStimulus(0, 5'd1, 3'd1, 8'h50, 0, 0, refEncode(0, 5'd1, 3'd1, 8'h50, 0, 0), "rst a");
    applyStimulus(1, 5'd0, 3'd2, 8'h64, 0, 0, refEncode(1, 5'd0, 3'd2, 8'h64, 0, 0), "rst b");
    applyStimulus(0, 5'h1F, 3'd0, 8'h84, 0, 0, refEncode(0, 5'h1F, 3'd0, 8'h84, 0, 0), "rst c");
    in_vld = 1'b0;
    #1 rstn = 1'b0;
    sb.delete();
    #1;
    checkOutput("rst out_vld", 32'(out_vld), 32'd0);
    checkOutput("rst posit_o", 32'(posit_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #2 rstn = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (out_vld !== 1'b0) stale++;
    end
    checkOutput("rst no stale", 32'(stale), 32'd0);
    @(posedge clk_i); #1;
    applyStimulus(0, 5'd0, 3'd2, 8'h40, 0, 0, 8'h50, "post-rst");
    checkLatency("latency post-rst");
    waitDrain("final drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
